tlul_rsp_intg_gen_buf: RTL

Device-side TL-UL response-channel stage that sits between a peripheral's raw response logic and the host-facing `tl_d2h_t` port. It computes response-command integrity and data integrity for every accepted D-channel beat, then holds the protected beat in a 2-entry buffer until the host accepts it. The block is the generating counterpart of the host-to-device command integrity checker, so every response leaving a device carries valid `d_user.rsp_intg` and `d_user.data_intg`.

---
 rtl/tlul_pkg.sv | 85 ++++++++
 rtl/tlul_rsp_intg_enc.sv | 21 ++
 rtl/tlul_rsp_intg_gen_buf.sv | 88 ++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// TL-UL response-channel types plus the SECDED encode/decode helpers used for
// response-command and data integrity.
package tlul_pkg;

  localparam int D2HRspMaxWidth = 57;
  localparam int DataMaxWidth   = 32;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic       d_valid;
    tl_d_op_e   d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic       d_sink;
    logic [DataMaxWidth-1:0] d_data;
    tl_d_user_t d_user;
    logic       d_error;
    logic       a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_d_op_e   opcode;
    logic [1:0] size;
    logic       error;
  } tl_d2h_rsp_intg_t;

  function automatic tl_d2h_rsp_intg_t extract_d2h_rsp_intg(tl_d2h_t tl);
    tl_d2h_rsp_intg_t r;
    r.opcode = tl.d_opcode;
    r.size   = tl.d_size;
    r.error  = tl.d_error;
    return r;
  endfunction

  // Inverted Hsiao code: the XOR constant keeps all-zero words from being valid.
  function automatic logic [63:0] prim_secded_inv_64_57_enc(logic [56:0] d);
    logic [63:0] o;
    o = 64'(d);
    o[57] = ^(o & 64'h0103FFF800007FFF);
    o[58] = ^(o & 64'h017C1FF801FF801F);
    o[59] = ^(o & 64'h01BDE1F87E0781E1);
    o[60] = ^(o & 64'h01DEEE3B8E388E22);
    o[61] = ^(o & 64'h01EF76CDB2C93244);
    o[62] = ^(o & 64'h01F7BB56D5525488);
    o[63] = ^(o & 64'h01FBDDA769A46910);
    return o ^ 64'h5400000000000000;
  endfunction

  function automatic logic [38:0] tlul_data_integ_enc(logic [31:0] d);
    logic [38:0] o;
    o = 39'(d);
    o[32] = ^(o & 39'h002606BD25);
    o[33] = ^(o & 39'h00DEBA8050);
    o[34] = ^(o & 39'h00413D89AA);
    o[35] = ^(o & 39'h0031234ED1);
    o[36] = ^(o & 39'h00C2C1323B);
    o[37] = ^(o & 39'h002DCC624C);
    o[38] = ^(o & 39'h0098505586);
    return o ^ 39'h2A00000000;
  endfunction

  // Decoders report only "syndrome non-zero"; correction is not needed here.
  function automatic logic prim_secded_inv_64_57_dec(logic [63:0] cw);
    logic [63:0] ref_cw;
    ref_cw = prim_secded_inv_64_57_enc(cw[56:0]);
    return |(ref_cw[63:57] ^ cw[63:57]);
  endfunction

  function automatic logic tlul_data_integ_dec(logic [38:0] cw);
    logic [38:0] ref_cw;
    ref_cw = tlul_data_integ_enc(cw[31:0]);
    return |(ref_cw[38:32] ^ cw[38:32]);
  endfunction

endpackage

// File: rtl/tlul_rsp_intg_enc.sv
// Combinational D-channel integrity generator: fills d_user.rsp_intg and
// d_user.data_intg, everything else passes through untouched.
module tlul_rsp_intg_enc
  import tlul_pkg::*;
(
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);

  logic [63:0] rsp_cw;
  logic [38:0] data_cw;

  always_comb begin
    rsp_cw  = prim_secded_inv_64_57_enc(D2HRspMaxWidth'(extract_d2h_rsp_intg(tl_i)));
    data_cw = tlul_data_integ_enc(tl_i.d_data);
    tl_o    = tl_i;
    tl_o.d_user.rsp_intg  = rsp_cw[63:57];
    tl_o.d_user.data_intg = data_cw[38:32];
  end

endmodule

// File: rtl/tlul_rsp_intg_gen_buf.sv
// Device-side response stage: integrity-encode each D beat, then hold it in a
// 2-entry buffer until the host accepts it. Optional self-check on the read
// entry is enabled by defining TLUL_RSP_INTG_SELFCHK_EN.
module tlul_rsp_intg_gen_buf
  import tlul_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_d2h_t tl_d2h_i,
  output logic    rsp_ready_o,
  input  logic    d_ready_i,
  output tl_d2h_t tl_d2h_o,
  output logic    err_o
);

  tl_d2h_t       enc;
  tl_d2h_t [1:0] mem_q;
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          out_vld, push, pop;

  tlul_rsp_intg_enc u_enc (
    .tl_i (tl_d2h_i),
    .tl_o (enc)
  );

  assign out_vld     = (count_q != 2'd0);
  assign rsp_ready_o = (count_q != 2'd2);
  assign push        = tl_d2h_i.d_valid & rsp_ready_o;
  assign pop         = out_vld & d_ready_i;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= enc;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Idle output is all-zero so stale entries never leak onto the bus.
  always_comb begin
    tl_d2h_o = '0;
    if (out_vld) begin
      tl_d2h_o         = mem_q[rd_ptr_q];
      tl_d2h_o.d_valid = 1'b1;
    end
    tl_d2h_o.a_ready = tl_d2h_i.a_ready;
  end

`ifdef TLUL_RSP_INTG_SELFCHK_EN
  tl_d2h_t rd_ent;
  logic    dec_err, err_q;

  always_comb begin
    rd_ent  = mem_q[rd_ptr_q];
    dec_err = prim_secded_inv_64_57_dec({rd_ent.d_user.rsp_intg,
                                         D2HRspMaxWidth'(extract_d2h_rsp_intg(rd_ent))}) |
              tlul_data_integ_dec({rd_ent.d_user.data_intg, rd_ent.d_data});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | (out_vld & dec_err);
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
